cas_writer: RTL and testbench

- Tape-record path of the SVI-328 core; the counterpart of the CAS playback reader.
- Samples the console's cassette-out bit, measures FSK periods, decodes framed bytes and writes them sequentially into the CAS buffer RAM.
- The buffer image can then be saved as a .CAS file or replayed by the playback path.
- Runs on clk_sys with a clock enable; sits between cv_console's tape output and the CAS spram write port.

---
 rtl/cas_writer_if.sv | 19 +
 rtl/cas_writer.sv | 200 ++++++++++++++++++++
 tb/tb_cas_writer.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cas_writer_if.sv
// ============================================================================
// Module   : cas_writer_if
// Brief    : CAS buffer RAM write port between the tape recorder and the spram.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface cas_writer_if #(
  parameter int AW = 16
);
  logic [AW-1:0] ram_a_o;
  logic [7:0]    ram_d_o;
  logic          ram_we_o;

  modport master (output ram_a_o, ram_d_o, ram_we_o);
  modport slave  (input  ram_a_o, ram_d_o, ram_we_o);
endinterface

`default_nettype wire

// File: rtl/cas_writer.sv
// ============================================================================
// Module   : cas_writer
// Brief    : Decodes FSK cassette-out bytes and writes them into the CAS buffer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cas_writer #(
  parameter int AW         = 16,
  parameter int CNT_W      = 16,
  parameter int PER_THRESH = 13312,
  parameter int TIMEOUT    = 40000
) (
  input  wire logic    clk_i,
  input  wire logic    reset_n_i,
  input  wire logic    clk_en_i,
  input  wire logic    record_i,
  input  wire logic    motor_i,
  input  wire logic    rewind_i,
  input  wire logic    tap_i,
  cas_writer_if.master ram,
  output logic [AW:0]  length_o,
  output logic         full_o,
  output logic         err_o,
  output logic         busy_o
);

  localparam logic [CNT_W-1:0] c_THRESH  = CNT_W'(PER_THRESH);
  localparam logic [CNT_W-1:0] c_TIMEOUT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_HUNT  = 2'd1,
    S_DATA  = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  state_t          r_state, w_state_nxt;
  logic            r_tap_s1, r_tap_s2, r_tap_d;
  logic [CNT_W-1:0] r_cnt;
  logic            r_latch, w_latch_nxt;
  logic            r_first, w_first_nxt;
  logic [7:0]      r_shift, w_shift_nxt;
  logic [7:0]      r_wdata;
  logic [2:0]      r_bitcnt, w_bitcnt_nxt;
  logic            w_err_set, w_wload;
  logic [AW-1:0]   r_ptr;
  logic [AW:0]     r_len;
  logic [AW:0]     w_len_inc;
  logic            r_full, r_err;
  logic            w_rise, w_short, w_timeout, w_active, w_write;

  assign w_rise    = r_tap_s2 & ~r_tap_d;
  assign w_short   = (r_cnt < c_THRESH);
  assign w_timeout = (r_cnt >= c_TIMEOUT);
  assign w_active  = record_i & motor_i & ~r_full;
  assign w_write   = (r_state == S_WRITE) & ~rewind_i;
  assign w_len_inc = r_len + (AW+1)'(1);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_tap_s1 <= 1'b0;
      r_tap_s2 <= 1'b0;
      r_tap_d  <= 1'b0;
    end else begin
      r_tap_s1 <= tap_i;
      r_tap_s2 <= r_tap_s1;
      r_tap_d  <= r_tap_s2;
    end
  end

  // Reload to 1 when the edge cycle itself carries a tick, so periods count whole ticks.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_cnt <= '0;
    end else if (w_rise) begin
      r_cnt <= clk_en_i ? CNT_W'(1) : '0;
    end else if (clk_en_i && (r_cnt != c_CNT_MAX)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) r_state <= S_IDLE;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_latch_nxt  = r_latch;
    w_first_nxt  = r_first;
    w_shift_nxt  = r_shift;
    w_bitcnt_nxt = r_bitcnt;
    w_err_set    = 1'b0;
    w_wload      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_first_nxt = 1'b1;
        w_latch_nxt = 1'b0;
        if (w_active) w_state_nxt = S_HUNT;
      end
      S_HUNT: begin
        if (w_timeout) begin
          w_latch_nxt = 1'b0;
        end else if (w_rise) begin
          if (r_first) begin
            w_first_nxt = 1'b0;
          end else if (w_short) begin
            if (r_latch) begin
              w_latch_nxt  = 1'b0;
              w_bitcnt_nxt = 3'd0;
              w_state_nxt  = S_DATA;
            end else begin
              w_latch_nxt = 1'b1;
            end
          end else begin
            w_latch_nxt = 1'b0;
          end
        end
      end
      S_DATA: begin
        if (w_timeout) begin
          w_err_set   = 1'b1;
          w_latch_nxt = 1'b0;
          w_state_nxt = S_HUNT;
        end else if (w_rise) begin
          if (w_short && !r_latch) begin
            w_latch_nxt = 1'b1;
          end else if (!w_short && r_latch) begin
            w_err_set   = 1'b1;
            w_latch_nxt = 1'b0;
            w_state_nxt = S_HUNT;
          end else begin
            // SHORT pair completes a 1; a lone LONG is a 0.
            w_latch_nxt  = 1'b0;
            w_shift_nxt  = {r_shift[6:0], w_short};
            w_bitcnt_nxt = r_bitcnt + 3'd1;
            if (r_bitcnt == 3'd7) begin
              w_wload     = 1'b1;
              w_state_nxt = S_WRITE;
            end
          end
        end
      end
      S_WRITE: w_state_nxt = S_HUNT;
      default: w_state_nxt = S_IDLE;
    endcase
    if (!w_active || rewind_i) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_latch  <= 1'b0;
      r_first  <= 1'b0;
      r_shift  <= 8'h00;
      r_bitcnt <= 3'd0;
      r_wdata  <= 8'h00;
    end else begin
      r_latch  <= w_latch_nxt;
      r_first  <= w_first_nxt;
      r_shift  <= w_shift_nxt;
      r_bitcnt <= w_bitcnt_nxt;
      if (w_wload) r_wdata <= w_shift_nxt;
    end
  end

  // The pointer parks on the last address once the buffer fills.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_ptr  <= '0;
      r_len  <= '0;
      r_full <= 1'b0;
      r_err  <= 1'b0;
    end else if (rewind_i) begin
      r_ptr  <= '0;
      r_len  <= '0;
      r_full <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      if (w_err_set) r_err <= 1'b1;
      if (w_write) begin
        r_len <= w_len_inc;
        if (w_len_inc[AW]) r_full <= 1'b1;
        else               r_ptr  <= r_ptr + AW'(1);
      end
    end
  end

  assign ram.ram_a_o  = r_ptr;
  assign ram.ram_d_o  = r_wdata;
  assign ram.ram_we_o = w_write;
  assign length_o     = r_len;
  assign full_o       = r_full;
  assign err_o        = r_err;
  assign busy_o       = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_cas_writer.sv
// ============================================================================
// Module   : tb_cas_writer
// Brief    : Directed bench for cas_writer (main instance plus a 4-byte buffer).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_cas_writer;

  localparam int c_SHORT = 14;
  localparam int c_LONG  = 28;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clk_en = 1'b1;
  logic record = 1'b1;
  logic motor = 1'b1;
  logic rewind = 1'b0;
  logic tap = 1'b0;

  logic [16:0] len1;
  logic        full1, err1, busy1;
  logic [2:0]  len2;
  logic        full2, err2, busy2;

  cas_writer_if #(.AW(16)) if1 ();
  cas_writer_if #(.AW(2))  if2 ();

  cas_writer #(.AW(16), .CNT_W(16), .PER_THRESH(20), .TIMEOUT(60)) u_dut (
    .clk_i(clk), .reset_n_i(rst_n), .clk_en_i(clk_en), .record_i(record),
    .motor_i(motor), .rewind_i(rewind), .tap_i(tap), .ram(if1),
    .length_o(len1), .full_o(full1), .err_o(err1), .busy_o(busy1)
  );

  cas_writer #(.AW(2), .CNT_W(16), .PER_THRESH(20), .TIMEOUT(60)) u_dut2 (
    .clk_i(clk), .reset_n_i(rst_n), .clk_en_i(clk_en), .record_i(record),
    .motor_i(motor), .rewind_i(rewind), .tap_i(tap), .ram(if2),
    .length_o(len2), .full_o(full2), .err_o(err2), .busy_o(busy2)
  );

  always #5 clk = ~clk;

  logic [15:0] q_a[$];
  logic [7:0]  q_d[$];
  logic [1:0]  q2_a[$];
  logic [7:0]  q2_d[$];

  always @(negedge clk) begin
    if (if1.ram_we_o) begin
      q_a.push_back(if1.ram_a_o);
      q_d.push_back(if1.ram_d_o);
    end
    if (if2.ram_we_o) begin
      q2_a.push_back(if2.ram_a_o);
      q2_d.push_back(if2.ram_d_o);
    end
  end

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] qa(input int i);
    return (i < q_a.size()) ? 32'(q_a[i]) : 32'hFFFF_FFFF;
  endfunction
  function automatic logic [31:0] qd(input int i);
    return (i < q_d.size()) ? 32'(q_d[i]) : 32'hFFFF_FFFF;
  endfunction
  function automatic logic [31:0] q2a(input int i);
    return (i < q2_a.size()) ? 32'(q2_a[i]) : 32'hFFFF_FFFF;
  endfunction
  function automatic logic [31:0] q2d(input int i);
    return (i < q2_d.size()) ? 32'(q2_d[i]) : 32'hFFFF_FFFF;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_period(input int len);
    tap = 1'b1;
    tick(len / 2);
    tap = 1'b0;
    tick(len - len / 2);
  endtask

  task automatic send_bit(input logic b);
    if (b) begin
      send_period(c_SHORT);
      send_period(c_SHORT);
    end else begin
      send_period(c_LONG);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bit(1'b1);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic preamble();
    for (int i = 0; i < 5; i++) send_period(c_LONG);
  endtask

  task automatic trail();
    for (int i = 0; i < 3; i++) send_period(c_LONG);
    tick(4);
  endtask

  task automatic do_rewind();
    rewind = 1'b1;
    tick(1);
    rewind = 1'b0;
    tick(2);
    q_a.delete();
    q_d.delete();
    q2_a.delete();
    q2_d.delete();
  endtask

  typedef struct {
    logic [7:0]  din;
    int          e_nwr;
    logic [15:0] e_addr;
    logic [7:0]  e_data;
    int          e_len;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{din: 8'hA5, e_nwr: 1, e_addr: 16'h0, e_data: 8'hA5, e_len: 1};
    vecs[1] = '{din: 8'h00, e_nwr: 1, e_addr: 16'h0, e_data: 8'h00, e_len: 1};
    vecs[2] = '{din: 8'hFF, e_nwr: 1, e_addr: 16'h0, e_data: 8'hFF, e_len: 1};
    vecs[3] = '{din: 8'h81, e_nwr: 1, e_addr: 16'h0, e_data: 8'h81, e_len: 1};
    vecs[4] = '{din: 8'h3C, e_nwr: 1, e_addr: 16'h0, e_data: 8'h3C, e_len: 1};

    tick(3);
    check("rst_addr", 32'(if1.ram_a_o), 0);
    check("rst_data", 32'(if1.ram_d_o), 0);
    check("rst_we", 32'(if1.ram_we_o), 0);
    check("rst_len", 32'(len1), 0);
    check("rst_full", 32'(full1), 0);
    check("rst_err", 32'(err1), 0);
    check("rst_busy", 32'(busy1), 0);
    rst_n = 1'b1;
    tick(2);
    check("busy_after_rst", 32'(busy1), 1);

    for (int v = 0; v < 5; v++) begin
      do_rewind();
      preamble();
      send_byte(vecs[v].din);
      trail();
      check($sformatf("v%0d_nwr", v), 32'(q_a.size()), 32'(vecs[v].e_nwr));
      check($sformatf("v%0d_addr", v), qa(0), 32'(vecs[v].e_addr));
      check($sformatf("v%0d_data", v), qd(0), 32'(vecs[v].e_data));
      check($sformatf("v%0d_len", v), 32'(len1), 32'(vecs[v].e_len));
      check($sformatf("v%0d_err", v), 32'(err1), 0);
      check($sformatf("v%0d_busy", v), 32'(busy1), 1);
    end

    // Back-to-back bytes
    do_rewind();
    preamble();
    send_byte(8'h7F);
    send_byte(8'h00);
    trail();
    check("b2b_nwr", 32'(q_a.size()), 2);
    check("b2b_a0", qa(0), 0);
    check("b2b_d0", qd(0), 32'h7F);
    check("b2b_a1", qa(1), 1);
    check("b2b_d1", qd(1), 32'h00);
    check("b2b_len", 32'(len1), 2);

    // SHORT then LONG inside a byte
    do_rewind();
    preamble();
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_period(c_SHORT);
    send_period(c_LONG);
    send_period(c_LONG);
    check("ferr_err", 32'(err1), 1);
    check("ferr_busy", 32'(busy1), 1);
    check("ferr_nwr", 32'(q_a.size()), 0);
    send_byte(8'h55);
    trail();
    check("ferr_next_nwr", 32'(q_a.size()), 1);
    check("ferr_next_addr", qa(0), 0);
    check("ferr_next_data", qd(0), 32'h55);
    check("ferr_len", 32'(len1), 1);

    // Small buffer fills after four bytes
    do_rewind();
    preamble();
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    send_byte(8'h55);
    send_byte(8'h66);
    trail();
    check("full_nwr", 32'(q2_a.size()), 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("full_a%0d", i), q2a(i), 32'(i));
      check($sformatf("full_d%0d", i), q2d(i), 32'(8'h11 * (i + 1)));
    end
    check("full_flag", 32'(full2), 1);
    check("full_len", 32'(len2), 4);
    check("full_busy", 32'(busy2), 0);

    // Rewind collides with the WRITE cycle
    do_rewind();
    preamble();
    send_byte(8'h11);
    send_bit(1'b1);
    for (int i = 7; i >= 0; i--) send_bit(1'(8'h3C >> i));
    tap = 1'b1;
    tick(3);
    rewind = 1'b1;
    #1;
    check("rwc_we", 32'(if1.ram_we_o), 0);
    check("rwc_busy", 32'(busy1), 1);
    tick(1);
    rewind = 1'b0;
    check("rwc_idle", 32'(busy1), 0);
    check("rwc_len", 32'(len1), 0);
    check("rwc_nwr", 32'(q_a.size()), 1);
    tick(4);
    tap = 1'b0;
    tick(c_SHORT / 2);
    preamble();
    send_byte(8'h42);
    trail();
    check("rwc_next_nwr", 32'(q_a.size()), 2);
    check("rwc_next_addr", qa(1), 0);
    check("rwc_next_data", qd(1), 32'h42);
    check("rwc_next_len", 32'(len1), 1);

    // Silence mid-byte, then motor drop mid-byte
    do_rewind();
    preamble();
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    check("tmo_pre_err", 32'(err1), 0);
    tick(70);
    check("tmo_err", 32'(err1), 1);
    check("tmo_busy", 32'(busy1), 1);
    send_period(c_LONG);
    send_period(c_LONG);
    send_bit(1'b1);
    send_bit(1'b0);
    send_period(c_SHORT);
    check("mot_busy_pre", 32'(busy1), 1);
    motor = 1'b0;
    tick(2);
    check("mot_busy", 32'(busy1), 0);
    check("mot_err", 32'(err1), 1);
    check("mot_nwr", 32'(q_a.size()), 0);
    motor = 1'b1;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
